// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU encodings, operand classes and classification helper
package fpu_pkg;
  localparam logic [1:0] FCMP_LE = 2'b00;
  localparam logic [1:0] FCMP_LT = 2'b01;
  localparam logic [1:0] FCMP_EQ = 2'b10;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int QNAN_BIT = 22;
  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fclass_t;
  function automatic fclass_t classify(input logic [30:0] x);
    return x[30:23] == 8'h00 ? (x[22:0] == '0 ? ZERO : SUB) :
           x[30:23] != EXP_MAX ? NORM :
           x[22:0] == '0 ? INF :
           x[QNAN_BIT] ? QNAN : SNAN;
  endfunction
endpackage

// File: rtl/fcmp_core.sv
// fcmp_core: combinational binary32 FEQ/FLT/FLE evaluation with invalid flag
module fcmp_core
  import fpu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  fclass_t     c1,
  input  fclass_t     c2,
  output logic        cmp,
  output logic        nv
);
  logic any_nan, any_snan, both_zero, eq, lt, mag_lt, mag_gt;
  assign any_snan  = c1 == SNAN || c2 == SNAN;
  assign any_nan   = any_snan || c1 == QNAN || c2 == QNAN;
  assign both_zero = c1 == ZERO && c2 == ZERO;
  assign mag_lt    = x1[30:0] < x2[30:0];
  assign mag_gt    = x1[30:0] > x2[30:0];
  assign eq = !any_nan && (both_zero || x1 == x2);
  // sign-magnitude order: opposite signs decide by sign, negatives reverse magnitude order
  assign lt = !any_nan && !both_zero &&
              (x1[31] != x2[31] ? x1[31] : (x1[31] ? mag_gt : mag_lt));
  always_comb begin
    cmp = op == FCMP_EQ ? eq : op == FCMP_LT ? lt : op == FCMP_LE ? (lt | eq) : 1'b0;
    nv  = op == FCMP_EQ ? any_snan : (op == FCMP_LT || op == FCMP_LE) ? any_nan : 1'b0;
  end
endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage valid/ready floating-point compare pipeline
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_data,
  output logic             out_nv
);
  logic             s1_valid, s2_valid, s2_en, cmp, nv;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_x1, s1_x2;
  fclass_t          s1_c1, s1_c2;
  assign s2_en     = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_en;
  assign out_valid = s2_valid;
  fcmp_core u_core (
    .op  (s1_op),
    .x1  (s1_x1),
    .x2  (s1_x2),
    .c1  (s1_c1),
    .c2  (s1_c2),
    .cmp (cmp),
    .nv  (nv)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_c1    <= ZERO;
      s1_c2    <= ZERO;
      out_tag  <= '0;
      out_data <= '0;
      out_nv   <= 1'b0;
    end else begin
      // flush overrides every transfer, including a request offered this cycle
      s1_valid <= !flush & (in_ready ? in_valid : s1_valid);
      s2_valid <= !flush & (s2_en ? s1_valid : s2_valid);
      if (in_valid && in_ready) begin
        s1_op  <= in_op;
        s1_tag <= in_tag;
        s1_x1  <= in_x1;
        s1_x2  <= in_x2;
        s1_c1  <= classify(in_x1[30:0]);
        s1_c2  <= classify(in_x2[30:0]);
      end
      if (s2_en && s1_valid) begin
        out_tag  <= s1_tag;
        out_data <= {31'b0, cmp};
        out_nv   <= nv;
      end
    end
  end
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed and randomized self-checking bench for fcmp_pipe
module tb_fcmp_pipe;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [4:0]  in_tag = '0;
  logic [31:0] in_x1 = '0;
  logic [31:0] in_x2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_tag;
  logic [31:0] out_data;
  logic        out_nv;
  int n_chk = 0;
  int n_fail = 0;

  fcmp_pipe #(.TAG_W(5)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .in_x1(in_x1), .in_x2(in_x2),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .out_nv(out_nv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: map each operand to a signed integer key so -0 and +0 coincide
  function automatic logic [1:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic an, bn, sn, lt, eq;
    longint ka, kb;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    sn = (an && !a[22]) || (bn && !b[22]);
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    lt = !(an || bn) && ka < kb;
    eq = !(an || bn) && ka == kb;
    case (op)
      2'b00: return {an || bn, lt || eq};
      2'b01: return {an || bn, lt};
      2'b10: return {sn, eq};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    logic [22:0] m;
    e = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) :
        ($urandom_range(0, 2) == 0 ? 8'h00 : 8'hFF);
    case ($urandom_range(0, 3))
      0: m = 23'h000000;
      1: m = 23'h000001;
      2: m = 23'h400000;
      default: m = 23'h7FFFFF;
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic c, input logic n);
    in_valid = 1'b1; in_op = op; in_x1 = a; in_x2 = b; in_tag = tag; out_ready = 1'b1;
    #1 chk({name, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_vld"}, out_valid, 1);
    chk({name, "_data"}, out_data, {31'b0, c});
    chk({name, "_nv"}, out_nv, n);
    chk({name, "_tag"}, out_tag, tag);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] e, va, vb;
    logic [1:0]  vop, r;
    int sent, idx;
    logic accepted;
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_nv", out_nv, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready, 1);

    run_op("eq_zeros", 2'b10, 32'h00000000, 32'h80000000, 5'h11, 1, 0);
    run_op("eq_qnan",  2'b10, 32'h7FC00000, 32'h7FC00000, 5'h12, 0, 0);
    run_op("eq_snan",  2'b10, 32'h7F800001, 32'h3F800000, 5'h13, 0, 1);
    run_op("lt_sign",  2'b01, 32'hBF800000, 32'h00000001, 5'h14, 1, 0);
    run_op("le_sub",   2'b00, 32'h00000002, 32'h00000001, 5'h15, 0, 0);
    run_op("lt_inf",   2'b01, 32'h7F800000, 32'hFF800000, 5'h16, 0, 0);
    run_op("le_qnan",  2'b00, 32'h7FC00000, 32'h3F800000, 5'h17, 0, 1);
    run_op("le_zeros", 2'b00, 32'h80000000, 32'h00000000, 5'h18, 1, 0);
    run_op("lt_negs",  2'b01, 32'hC0000000, 32'hBF800000, 5'h19, 1, 0);
    run_op("lt_subn",  2'b01, 32'h00000001, 32'h00800000, 5'h1A, 1, 0);
    run_op("lt_qnan",  2'b01, 32'h7FC00000, 32'h7FC00000, 5'h1B, 0, 1);
    run_op("rsvd",     2'b11, 32'h3F800000, 32'h3F800000, 5'h1C, 0, 0);
    @(posedge clk); #1;

    // backpressure: fill both stages, then release
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b10; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000;
    in_tag = 5'd1;
    #1 chk("bp_rdy1", in_ready, 1);
    @(posedge clk); #1;
    in_tag = 5'd2;
    #1 chk("bp_rdy2", in_ready, 1);
    @(posedge clk); #1;
    in_tag = 5'd3;
    #1 chk("bp_full", in_ready, 0);
    chk("bp_tag1", out_tag, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_rdy", in_ready, 0);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_tag", out_tag, 1);
      chk("bp_hold_data", out_data, 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", in_ready, 1);
    chk("bp_rel_tag1", out_tag, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_vld2", out_valid, 1);
    chk("bp_tag2", out_tag, 2);
    @(posedge clk); #1;
    chk("bp_vld3", out_valid, 1);
    chk("bp_tag3", out_tag, 3);
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);

    // flush with both stages full and a request offered
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd4;
    @(posedge clk); #1;
    in_tag = 5'd5;
    @(posedge clk); #1;
    chk("fl_full", out_valid, 1);
    in_tag = 5'd6; flush = 1'b1; out_ready = 1'b1;
    #1 chk("fl_rdy", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fl_stale", out_valid, 0);
    end

    // asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd7;
    @(posedge clk); #1;
    in_tag = 5'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_full", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_tag", out_tag, 0);
    chk("ar_data", out_data, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    run_op("ar_first", 2'b01, 32'hBF800000, 32'h3F800000, 5'h09, 1, 0);
    @(posedge clk); #1;
    chk("ar_ghost", out_valid, 0);

    // randomized stream with random backpressure against the reference model
    sent = 0; idx = 0; accepted = 1'b0;
    out_ready = 1'b1; in_valid = 1'b0;
    for (int cyc = 0; cyc < 5000 && (sent < 400 || q.size() > 0); cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sw_extra", 1, 0);
        else begin
          e = q.pop_front();
          chk("sw_data", out_data, {31'b0, e[0]});
          chk("sw_nv", out_nv, e[1]);
          chk("sw_tag", out_tag, e[6:2]);
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        r = model(in_op, in_x1, in_x2);
        q.push_back({25'b0, in_tag, r});
        sent++;
      end
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 3) != 0;
      if (!in_valid || accepted) begin
        if (sent + (in_valid ? 0 : 0) < 400 && idx < 400 && $urandom_range(0, 3) != 0) begin
          va = rnd_f();
          case ($urandom_range(0, 3))
            0: vb = va;
            1: vb = {~va[31], va[30:0]};
            default: vb = rnd_f();
          endcase
          vop = 2'($urandom_range(0, 3));
          in_valid = 1'b1; in_op = vop; in_x1 = va; in_x2 = vb; in_tag = 5'(idx);
          idx++;
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("sw_drain", q.size(), 0);
    chk("sw_sent", sent, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
